packet_split_buffered: RTL and testbench
========================================

Name: packet_split_buffered

Overview:
- Clocked one-to-two packet splitter; the dispatch counterpart of the two-to-one arbitrated merge.
- Accepts one WIDTH-bit packet per cycle on a valid/ready input.
- Bit SEL_BIT of each packet picks its destination port: 0 → out0, 1 → out1.
- Each destination has its own circular FIFO, so a stalled output does not block traffic to the other output until the blocked FIFO fills.
- Sits on the mesh router output side, feeding per-direction links.

Parameters:
- WIDTH, 8, packet width in bits (≥2).
- SEL_BIT, 7, bit index of the destination select bit; must be < WIDTH.
- DEPTH, 4, entries per output FIFO; power of two, ≥2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input packet present.
- in_ready  output  1  splitter can accept the presented packet.
- in_data  input  WIDTH  input packet.
- out0_valid  output  1  out0 FIFO head valid.
- out0_ready  input  1  downstream consumer of out0 ready.
- out0_data  output  WIDTH  out0 FIFO head.
- out1_valid  output  1  out1 FIFO head valid.
- out1_ready  input  1  downstream consumer of out1 ready.
- out1_data  output  WIDTH  out1 FIFO head.

Behaviour:
- Reset (asynchronous assertion, synchronous-safe release):
  - All FIFO pointers and counts clear to 0.
  - out0_valid and out1_valid = 0; out*_data = 0.
  - Any packet held mid-FIFO is discarded.
  - in_ready = 0 while rst_n is low.
- Routing: sel = in_data[SEL_BIT]. The packet is stored unmodified, with the select bit retained.
- Ready rule: in_ready = rst_n && !full[sel].
  - in_ready depends on in_data but never on in_valid.
  - Upstream must hold in_data stable while in_valid && !in_ready.
- Accept: a transfer occurs when in_valid && in_ready at a clock edge.
  - The packet is written at wr_ptr[sel].
  - wr_ptr[sel] increments modulo DEPTH.
  - count[sel] increments.
- Output side, per port k:
  - outk_valid = (count[k] != 0).
  - outk_data = mem[k][rd_ptr[k]].
  - On outk_valid && outk_ready, rd_ptr[k] increments modulo DEPTH and count[k] decrements.
- Latency:
  - A packet accepted at edge n is visible on outk at cycle n+1.
  - There is no combinational in→out bypass.
  - Minimum fall-through is 1 cycle.
- Stability: while outk_valid && !outk_ready, outk_data and outk_valid hold unchanged.
- Ordering: per-output order is FIFO. Packets to different outputs are independent.
- Full (count[k] == DEPTH):
  - in_ready is low for packets targeting k, even if outk pops that same cycle; there is no push-on-full-with-pop.
  - Packets targeting the other port are still accepted.
- Empty (count[k] == 0): outk_valid = 0 and outk_ready is ignored.
- Simultaneous push and pop on the same non-full, non-empty port: count[k] is unchanged and both pointers advance.
- Pointer wrap: pointers are log2(DEPTH) bits wide and wrap naturally. count is log2(DEPTH)+1 bits wide.
- Per-port state is two-state: EMPTY (count = 0) and ACTIVE (count > 0). FULL is a sub-condition of ACTIVE (count = DEPTH). There is no other FSM.
- Head-of-line: if the presented packet targets a full port, the input stalls. Later packets are not reordered around it.

Optional Feature:
- Macro: PACKET_SPLIT_STATS_EN.
- When defined, the block adds these outputs:
  - stat_cnt0 [15:0] and stat_cnt1 [15:0]: packets accepted per port. Each increments on accept and saturates at 16'hFFFF.
  - stat_stall [15:0]: cycles with in_valid && !in_ready, saturating.
- All counters reset to 0 on rst_n low.
- When not defined, these ports and their logic are absent. Routing behaviour is identical in both builds.

Test Plan:
1. Reset mid-traffic: push 8'h85, 8'h03; assert rst_n low before either pops → out0_valid = out1_valid = 0 and in_ready = 0 immediately; after release, counts are 0 and 8'h85 never appears.
2. Basic routing: send 8'h05 then 8'h81 with both readies high → out0_data = 8'h05 one cycle after accept, out1_data = 8'h81 one cycle after its accept.
3. Full/isolation: out1_ready = 0; send 8'h80–8'h83 (fills out1) then 8'h84 → in_ready = 0 while 8'h84 is presented. Switching input to 8'h10 then gives in_ready = 1 and out0_data = 8'h10.
4. Backpressure stability: out0_ready low for 5 cycles with head 8'h22 → out0_data = 8'h22 and out0_valid = 1 held all 5 cycles.
5. Wrap and simultaneous push/pop: stream 10 packets 8'h00–8'h09 to out0 with out0_ready toggling 1/0 → out0 emits 00–09 in order; count never exceeds 4 and returns to 0.
6. Stats (PACKET_SPLIT_STATS_EN defined): 3 packets to out0, 2 to out1, 4 stall cycles → stat_cnt0 = 3, stat_cnt1 = 2, stat_stall = 4.

Source files
------------

// File: rtl/packet_split_buffered_if.sv
// Handshake bundle for the one-to-two packet splitter: one input stream and two output streams.
// The slave modport is the splitter side; master is the upstream/downstream side.
interface packet_split_buffered_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;

  modport master (
    output in_valid, in_data, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  modport slave (
    input  in_valid, in_data, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );
endinterface

// File: rtl/packet_split_buffered.sv
// One-to-two packet splitter: in_data[SEL_BIT] steers each packet into a per-port circular FIFO.
// Optional per-port accept counters and a stall counter are enabled with `define PACKET_SPLIT_STATS_EN.
module packet_split_buffered #(
  parameter int WIDTH   = 8,
  parameter int SEL_BIT = 7,
  parameter int DEPTH   = 4
) (
  input  logic clk,
  input  logic rst_n,
  packet_split_buffered_if.slave bus
`ifdef PACKET_SPLIT_STATS_EN
  ,
  output logic [15:0] stat_cnt0,
  output logic [15:0] stat_cnt1,
  output logic [15:0] stat_stall
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {EMPTY = 1'b0, ACTIVE = 1'b1} port_state_t;

  logic [WIDTH-1:0] mem [2][DEPTH];
  logic [PW-1:0]    wr_ptr [2];
  logic [PW-1:0]    rd_ptr [2];
  logic [CW-1:0]    count [2];
  logic [CW-1:0]    count_nxt [2];
  port_state_t      state [2];

  logic       sel;
  logic [1:0] full;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_ready;

  assign sel       = bus.in_data[SEL_BIT];
  assign out_ready = {bus.out1_ready, bus.out0_ready};

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      full[k] = (count[k] == CW'(DEPTH));
    end
  end

  // Full blocks a push even when the same port pops this cycle.
  assign bus.in_ready = rst_n && !full[sel];
  assign push[0]      = bus.in_valid && bus.in_ready && !sel;
  assign push[1]      = bus.in_valid && bus.in_ready &&  sel;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      pop[k]       = (state[k] == ACTIVE) && out_ready[k];
      count_nxt[k] = count[k];
      if (push[k] && !pop[k]) begin
        count_nxt[k] = count[k] + CW'(1);
      end else if (!push[k] && pop[k]) begin
        count_nxt[k] = count[k] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
        state[k]  <= EMPTY;
        for (int i = 0; i < DEPTH; i++) begin
          mem[k][i] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push[k]) begin
          mem[k][wr_ptr[k]] <= bus.in_data;
          wr_ptr[k]         <= wr_ptr[k] + PW'(1);
        end
        if (pop[k]) begin
          rd_ptr[k] <= rd_ptr[k] + PW'(1);
        end
        count[k] <= count_nxt[k];
        state[k] <= (count_nxt[k] != '0) ? ACTIVE : EMPTY;
      end
    end
  end

  // Heads come straight from storage, so a packet shows up the cycle after it is written.
  assign bus.out0_valid = (state[0] == ACTIVE);
  assign bus.out1_valid = (state[1] == ACTIVE);
  assign bus.out0_data  = mem[0][rd_ptr[0]];
  assign bus.out1_data  = mem[1][rd_ptr[1]];

`ifdef PACKET_SPLIT_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt0  <= '0;
      stat_cnt1  <= '0;
      stat_stall <= '0;
    end else begin
      if (push[0]) stat_cnt0 <= sat_inc(stat_cnt0);
      if (push[1]) stat_cnt1 <= sat_inc(stat_cnt1);
      if (bus.in_valid && !bus.in_ready) stat_stall <= sat_inc(stat_stall);
    end
  end
`endif

endmodule

// File: tb/tb_packet_split_buffered.sv
// Scoreboard bench for packet_split_buffered: accepted packets are queued per port and
// compared in order as each output handshakes.
module tb_packet_split_buffered;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  packet_split_buffered_if #(.WIDTH(8)) bus ();

`ifdef PACKET_SPLIT_STATS_EN
  logic [15:0] stat_cnt0, stat_cnt1, stat_stall;
`endif

  packet_split_buffered #(.WIDTH(8), .SEL_BIT(7), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef PACKET_SPLIT_STATS_EN
    ,
    .stat_cnt0  (stat_cnt0),
    .stat_cnt1  (stat_cnt1),
    .stat_stall (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] d);
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check_val("send_timeout", 32'(d), 32'hFFFF_FFFF);
      @(posedge clk);
    end else begin
      @(posedge clk);
      if (d[7]) q1.push_back(d);
      else      q0.push_back(d);
    end
    #1 bus.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.out0_valid && bus.out0_ready) begin
      if (q0.size() == 0) check_val("out0_spurious", 32'(bus.out0_data), 32'hDEAD);
      else                check_val("out0_data", 32'(bus.out0_data), 32'(q0.pop_front()));
    end
    if (bus.out1_valid && bus.out1_ready) begin
      if (q1.size() == 0) check_val("out1_spurious", 32'(bus.out1_data), 32'hDEAD);
      else                check_val("out1_data", 32'(bus.out1_data), 32'(q1.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = 8'h00;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    #1;
    check_val("rst_in_ready", 32'(bus.in_ready), 0);
    check_val("rst_out0_valid", 32'(bus.out0_valid), 0);
    check_val("rst_out1_valid", 32'(bus.out1_valid), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset while packets sit in both FIFOs
    send(8'h85);
    send(8'h03);
    check_val("pre_rst_out1_valid", 32'(bus.out1_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_out0_valid", 32'(bus.out0_valid), 0);
    check_val("mid_rst_out1_valid", 32'(bus.out1_valid), 0);
    check_val("mid_rst_in_ready", 32'(bus.in_ready), 0);
    check_val("mid_rst_out1_data", 32'(bus.out1_data), 0);
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("post_rst_out0_valid", 32'(bus.out0_valid), 0);
    check_val("post_rst_out1_valid", 32'(bus.out1_valid), 0);
    check_val("post_rst_in_ready", 32'(bus.in_ready), 1);
    check_val("post_rst_out0_data", 32'(bus.out0_data), 0);

    // Basic routing and one-cycle latency
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h05;
    @(negedge clk);
    check_val("no_bypass", 32'(bus.out0_valid), 0);
    @(posedge clk);
    q0.push_back(8'h05);
    #1 bus.in_valid = 1'b0;
    check_val("route0_valid", 32'(bus.out0_valid), 1);
    check_val("route0_data", 32'(bus.out0_data), 32'h05);
    check_val("route0_not1", 32'(bus.out1_valid), 0);
    send(8'h81);
    check_val("route1_valid", 32'(bus.out1_valid), 1);
    check_val("route1_data", 32'(bus.out1_data), 32'h81);
    repeat (3) @(posedge clk); #1;

    // Full out1 blocks its traffic but not out0
    bus.out1_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h80 + 8'(i));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h84;
    @(negedge clk);
    check_val("full_block_a", 32'(bus.in_ready), 0);
    @(negedge clk);
    check_val("full_block_b", 32'(bus.in_ready), 0);
    bus.in_data = 8'h10;
    #1;
    check_val("other_port_ok", 32'(bus.in_ready), 1);
    @(posedge clk);
    q0.push_back(8'h10);
    #1 bus.in_valid = 1'b0;
    check_val("iso_out0_data", 32'(bus.out0_data), 32'h10);
    check_val("iso_out1_head", 32'(bus.out1_data), 32'h80);
    bus.in_data = 8'h84;
    bus.out1_ready = 1'b1;
    #1;
    check_val("full_with_pop", 32'(bus.in_ready), 0);
    repeat (8) @(posedge clk); #1;
    check_val("out1_drained", q1.size(), 0);

    // Backpressure holds the head
    bus.out0_ready = 1'b0;
    send(8'h22);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("hold_valid", 32'(bus.out0_valid), 1);
      check_val("hold_data", 32'(bus.out0_data), 32'h22);
    end
    @(posedge clk); #1;
    bus.out0_ready = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Wrap with toggling ready on out0
    bus.out0_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(8'(i));
      end
      begin
        repeat (24) begin
          @(posedge clk);
          #1 bus.out0_ready = ~bus.out0_ready;
        end
      end
    join
    @(posedge clk); #1;
    bus.out0_ready = 1'b1;
    repeat (8) @(posedge clk); #1;
    check_val("wrap_drained", q0.size(), 0);
    check_val("wrap_empty", 32'(bus.out0_valid), 0);

`ifdef PACKET_SPLIT_STATS_EN
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("stat_rst", 32'(stat_cnt0), 0);
    for (int i = 0; i < 3; i++) send(8'h30 + 8'(i));
    send(8'hA0);
    send(8'hA1);
    check_val("stat_cnt0", 32'(stat_cnt0), 3);
    check_val("stat_cnt1", 32'(stat_cnt1), 2);
    check_val("stat_stall0", 32'(stat_stall), 0);
    repeat (3) @(posedge clk); #1;
    bus.out1_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'hB0 + 8'(i));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hBF;
    repeat (4) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    check_val("stat_stall", 32'(stat_stall), 4);
    check_val("stat_cnt1_full", 32'(stat_cnt1), 6);
    bus.out1_ready = 1'b1;
    repeat (8) @(posedge clk); #1;
    check_val("stat_drained", q1.size(), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
